// File: rtl/mips_instr_encoder.sv
// Symbolic MIPS instruction encoder with an output FIFO that streams
// encoded words into instruction memory at auto-incrementing addresses.
module mips_instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_kind,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_shamt,
    input  logic [15:0] req_imm,
    input  logic [25:0] req_target,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [31:0] wr_data,
    output logic [31:0] wr_addr,
    output logic [15:0] words_written,
    output logic        err_illegal
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [31:0]   LAST_IDX = 32'(MEM_WORDS - 1);

    localparam logic [4:0] K_ADD  = 5'd0;
    localparam logic [4:0] K_SUB  = 5'd1;
    localparam logic [4:0] K_AND  = 5'd2;
    localparam logic [4:0] K_OR   = 5'd3;
    localparam logic [4:0] K_NOR  = 5'd4;
    localparam logic [4:0] K_SLT  = 5'd5;
    localparam logic [4:0] K_SLL  = 5'd6;
    localparam logic [4:0] K_SRL  = 5'd7;
    localparam logic [4:0] K_JR   = 5'd8;
    localparam logic [4:0] K_ADDI = 5'd9;
    localparam logic [4:0] K_ANDI = 5'd10;
    localparam logic [4:0] K_ORI  = 5'd11;
    localparam logic [4:0] K_LUI  = 5'd12;
    localparam logic [4:0] K_LW   = 5'd13;
    localparam logic [4:0] K_SW   = 5'd14;
    localparam logic [4:0] K_BEQ  = 5'd15;
    localparam logic [4:0] K_BNE  = 5'd16;
    localparam logic [4:0] K_J    = 5'd17;
    localparam logic [4:0] K_JAL  = 5'd18;

    localparam logic [5:0] OP_R = 6'h00;

    logic [31:0]   w_word;
    logic          w_legal;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_addr;
    logic [31:0]   r_idx;
    logic [15:0]   r_words;
    logic          r_err;

    // Each kind keeps only the fields its format uses; the rest are zero.
    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (req_kind)
            K_ADD:  w_word = {OP_R, req_rs, req_rt, req_rd, 5'd0, 6'h20};
            K_SUB:  w_word = {OP_R, req_rs, req_rt, req_rd, 5'd0, 6'h22};
            K_AND:  w_word = {OP_R, req_rs, req_rt, req_rd, 5'd0, 6'h24};
            K_OR:   w_word = {OP_R, req_rs, req_rt, req_rd, 5'd0, 6'h25};
            K_NOR:  w_word = {OP_R, req_rs, req_rt, req_rd, 5'd0, 6'h27};
            K_SLT:  w_word = {OP_R, req_rs, req_rt, req_rd, 5'd0, 6'h2A};
            K_SLL:  w_word = {OP_R, 5'd0, req_rt, req_rd, req_shamt, 6'h00};
            K_SRL:  w_word = {OP_R, 5'd0, req_rt, req_rd, req_shamt, 6'h02};
            K_JR:   w_word = {OP_R, req_rs, 5'd0, 5'd0, 5'd0, 6'h08};
            K_ADDI: w_word = {6'h08, req_rs, req_rt, req_imm};
            K_ANDI: w_word = {6'h0C, req_rs, req_rt, req_imm};
            K_ORI:  w_word = {6'h0D, req_rs, req_rt, req_imm};
            K_LUI:  w_word = {6'h0F, 5'd0, req_rt, req_imm};
            K_LW:   w_word = {6'h23, req_rs, req_rt, req_imm};
            K_SW:   w_word = {6'h2B, req_rs, req_rt, req_imm};
            K_BEQ:  w_word = {6'h04, req_rs, req_rt, req_imm};
            K_BNE:  w_word = {6'h05, req_rs, req_rt, req_imm};
            K_J:    w_word = {6'h02, req_target};
            K_JAL:  w_word = {6'h03, req_target};
            default: begin
                w_word  = '0;
                w_legal = 1'b0;
            end
        endcase
    end

    assign req_ready     = (r_count < FULL_CNT);
    assign wr_valid      = (r_count != '0);
    assign w_accept      = req_valid & req_ready & ~flush;
    assign w_push        = w_accept & w_legal;
    assign w_pop         = wr_valid & wr_ready & ~flush;
    assign wr_data       = wr_valid ? r_mem[r_rptr] : 32'd0;
    assign wr_addr       = r_addr;
    assign words_written = r_words;
    assign err_illegal   = r_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Write index runs 0..MEM_WORDS-1 so the address wraps to the base.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= BASE_ADDR;
            r_idx  <= '0;
        end else if (flush) begin
            r_addr <= BASE_ADDR;
            r_idx  <= '0;
        end else if (w_pop) begin
            if (r_idx == LAST_IDX) begin
                r_addr <= BASE_ADDR;
                r_idx  <= '0;
            end else begin
                r_addr <= r_addr + 32'd4;
                r_idx  <= r_idx + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_words <= '0;
        end else if (w_pop) begin
            r_words <= r_words + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept & ~w_legal) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed scenarios then
// randomized requests with random back-pressure and flushes.
module tb_mips_instr_encoder;

    localparam int          DEPTH = 4;
    localparam int          MW    = 4;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    localparam int FN  [9] = '{32, 34, 36, 37, 39, 42, 0, 2, 8};
    localparam int IOP [8] = '{8, 12, 13, 15, 35, 43, 4, 5};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_kind = '0;
    logic [4:0]  req_rs = '0;
    logic [4:0]  req_rt = '0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_shamt = '0;
    logic [15:0] req_imm = '0;
    logic [25:0] req_target = '0;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [31:0] wr_data;
    logic [31:0] wr_addr;
    logic [15:0] words_written;
    logic        err_illegal;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] q[$];
    bit          m_err = 1'b0;
    int          m_idx = 0;
    int          m_cnt = 0;
    bit          rnd_done = 1'b0;

    mips_instr_encoder #(
        .DEPTH(DEPTH),
        .BASE_ADDR(BASE),
        .MEM_WORDS(MW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_kind(req_kind),
        .req_rs(req_rs),
        .req_rt(req_rt),
        .req_rd(req_rd),
        .req_shamt(req_shamt),
        .req_imm(req_imm),
        .req_target(req_target),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .wr_addr(wr_addr),
        .words_written(words_written),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // Reference encoder built from field positions and opcode tables.
    function automatic bit ref_enc(input int k, input int rs, input int rt,
                                   input int rd, input int sh, input int imm,
                                   input int tgt, output logic [31:0] w);
        longint v;
        v = 0;
        if (k <= 8) begin
            if (k == 6 || k == 7) rs = 0;
            else sh = 0;
            if (k == 8) begin
                rt = 0;
                rd = 0;
            end
            v = rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + FN[k];
        end else if (k <= 16) begin
            if (k == 12) rs = 0;
            v = longint'(IOP[k-9]) * 67108864 + rs * 2097152 + rt * 65536 + imm;
        end else if (k <= 18) begin
            v = longint'(k - 15) * 67108864 + tgt;
        end else begin
            w = '0;
            return 1'b0;
        end
        w = v[31:0];
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Stimulus-side observer: records every accepted request.
    always @(negedge clk) begin
        logic [31:0] w;
        bit ok;
        if (!reset && !flush && req_valid && req_ready) begin
            ok = ref_enc(int'(req_kind), int'(req_rs), int'(req_rt),
                         int'(req_rd), int'(req_shamt), int'(req_imm),
                         int'(req_target), w);
            #1;
            if (ok) q.push_back(w);
            else m_err = 1'b1;
        end
    end

    // Monitor: compares DUT state and the head word against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            m_idx = 0;
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            chk("wr_valid", 32'(wr_valid), 32'(q.size() != 0));
            chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
            chk("err_illegal", 32'(err_illegal), 32'(m_err));
            chk("words_written", 32'(words_written), 32'(m_cnt % 65536));
            if (q.size() != 0) begin
                chk("wr_data", wr_data, q[0]);
                chk("wr_addr", wr_addr, BASE + 32'(4 * (m_idx % MW)));
            end else begin
                chk("wr_data_idle", wr_data, 32'd0);
            end
            if (flush) begin
                q.delete();
                m_idx = 0;
            end else if (wr_ready && q.size() != 0) begin
                void'(q.pop_front());
                m_idx++;
                m_cnt++;
            end
        end
    end

    task automatic send(input int k, input int rs, input int rt, input int rd,
                        input int sh, input int imm, input int tgt);
        bit got;
        got = 1'b0;
        req_kind   = 5'(k);
        req_rs     = 5'(rs);
        req_rt     = 5'(rt);
        req_rd     = 5'(rd);
        req_shamt  = 5'(sh);
        req_imm    = 16'(imm);
        req_target = 26'(tgt);
        req_valid  = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (req_ready && !flush) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 kind=%0d", k);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        bit empty;
        empty = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(posedge clk);
            if (q.size() == 0) begin
                empty = 1'b1;
                break;
            end
        end
        #1;
        checks++;
        if (!empty) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        wr_ready = 1'b1;

        send(0, 8, 9, 10, 0, 0, 0);
        idle(3);
        send(13, 29, 8, 0, 0, 4, 0);
        send(12, 5, 1, 0, 0, 16'h1001, 0);
        send(17, 0, 0, 0, 0, 0, 26'h0100000);
        send(18, 0, 0, 0, 0, 0, 26'h0100000);
        send(15, 8, 9, 0, 0, 16'hFFFF, 0);
        send(6, 7, 3, 4, 5, 16'hABCD, 26'h3FFFFFF);
        send(8, 31, 2, 3, 4, 16'h1234, 0);
        drain(50);

        wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1 + i, i, i + 1, i + 2, 3, 0, 0);
        fork
            send(9, 4, 5, 0, 0, 16'h8001, 0);
            begin
                idle(5);
                wr_ready = 1'b1;
            end
        join
        drain(50);

        send(25, 1, 2, 3, 4, 5, 6);
        idle(2);
        send(0, 8, 9, 10, 0, 0, 0);
        drain(20);
        pulse_flush();
        idle(3);

        req_kind  = 5'd2;
        req_rs    = 5'd3;
        req_valid = 1'b1;
        flush     = 1'b1;
        idle(1);
        req_valid = 1'b0;
        flush     = 1'b0;
        idle(3);

        wr_ready = 1'b0;
        send(11, 1, 2, 0, 0, 7, 0);
        send(14, 3, 4, 0, 0, 8, 0);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(2);
        wr_ready = 1'b1;
        idle(2);

        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    wr_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int n = 0; n < 300; n++) begin
                    int k;
                    k = ($urandom_range(0, 9) == 0) ? $urandom_range(19, 31)
                                                     : $urandom_range(0, 18);
                    send(k, $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 65535), $urandom_range(0, 32'h3FFFFFF));
                    if ($urandom_range(0, 39) == 0) pulse_flush();
                    if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
                end
                rnd_done = 1'b1;
            end
        join
        wr_ready = 1'b1;
        drain(100);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
